// File: rtl/cacheline_burst_adapter.sv
// Cache-line <-> memory-burst adapter: assembles fill beats into one line and
// serializes evicted lines into ascending beats, with a one-cycle resp_o on completion.
module cacheline_burst_adapter #(
    parameter int s_offset = 5,
    parameter int s_burst  = 64,
    parameter int s_addr   = 32
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        read_i,
    input  logic                        write_i,
    input  logic [s_addr-1:0]           address_i,
    input  logic [8*(2**s_offset)-1:0]  line_i,
    output logic [8*(2**s_offset)-1:0]  line_o,
    output logic                        resp_o,
    output logic [s_addr-1:0]           address_o,
    output logic                        read_o,
    output logic                        write_o,
    output logic [s_burst-1:0]          burst_o,
    input  logic [s_burst-1:0]          burst_i,
    input  logic                        resp_i
);
    localparam int s_line = 8 * (2 ** s_offset);
    localparam int beats  = s_line / s_burst;
    localparam int cw     = (beats > 1) ? $clog2(beats) : 1;
    localparam logic [cw-1:0] last_cnt = cw'(beats - 1);

    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

    state_t               r_state;
    logic [cw-1:0]        r_cnt;
    logic [s_addr-1:0]    r_addr;
    logic                 r_read;
    logic                 r_write;
    logic                 r_resp;
    logic [s_burst-1:0]   r_burst;

    logic [cw-1:0]                    w_cnt_inc;
    logic                             w_take_write;
    logic [beats-1:0][s_burst-1:0]    w_wbuf_all;

    assign w_cnt_inc    = r_cnt + cw'(1);
    assign w_take_write = !read_i && write_i;

    // One register pair per beat: the fill slot and the writeback buffer slot.
    for (genvar gi = 0; gi < beats; gi++) begin : g_beat
        localparam logic [cw-1:0] idx = cw'(gi);
        logic [s_burst-1:0] r_fill;
        logic [s_burst-1:0] r_wbuf;

        always_ff @(posedge clk) begin
            if (rst) begin
                r_fill <= '0;
                r_wbuf <= '0;
            end else begin
                if (r_state == READ && resp_i && r_cnt == idx)
                    r_fill <= burst_i;
                if (r_state == IDLE && w_take_write)
                    r_wbuf <= line_i[gi*s_burst +: s_burst];
            end
        end

        assign line_o[gi*s_burst +: s_burst] = r_fill;
        assign w_wbuf_all[gi] = r_wbuf;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_addr  <= '0;
            r_read  <= 1'b0;
            r_write <= 1'b0;
            r_resp  <= 1'b0;
            r_burst <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_resp <= 1'b0;
                    if (read_i) begin
                        r_addr  <= {address_i[s_addr-1:s_offset], {s_offset{1'b0}}};
                        r_cnt   <= '0;
                        r_read  <= 1'b1;
                        r_state <= READ;
                    end else if (write_i) begin
                        r_addr  <= {address_i[s_addr-1:s_offset], {s_offset{1'b0}}};
                        r_cnt   <= '0;
                        r_write <= 1'b1;
                        r_burst <= line_i[s_burst-1:0];
                        r_state <= WRITE;
                    end
                end
                READ: begin
                    if (resp_i) begin
                        r_cnt <= w_cnt_inc;
                        if (r_cnt == last_cnt) begin
                            r_read  <= 1'b0;
                            r_resp  <= 1'b1;
                            r_state <= DONE;
                        end
                    end
                end
                WRITE: begin
                    // burst_o is preloaded with the next beat so it stays a plain register.
                    if (resp_i) begin
                        r_cnt <= w_cnt_inc;
                        if (r_cnt == last_cnt) begin
                            r_write <= 1'b0;
                            r_burst <= '0;
                            r_resp  <= 1'b1;
                            r_state <= DONE;
                        end else begin
                            r_burst <= w_wbuf_all[w_cnt_inc];
                        end
                    end
                end
                DONE: begin
                    r_resp  <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign address_o = r_addr;
    assign read_o    = r_read;
    assign write_o   = r_write;
    assign resp_o    = r_resp;
    assign burst_o   = r_burst;

endmodule

// File: tb/tb_cacheline_burst_adapter.sv
// Scoreboard bench for cacheline_burst_adapter: drivers push expected and observed
// lines/beats to queues, each test task pops and compares them.
module tb_cacheline_burst_adapter;
    localparam int LINE = 256;

    logic            clk = 1'b0;
    logic            rst;
    logic            read_i, write_i, resp_i;
    logic [31:0]     address_i;
    logic [LINE-1:0] line_i;
    logic [LINE-1:0] line_o;
    logic            resp_o, read_o, write_o;
    logic [31:0]     address_o;
    logic [63:0]     burst_o, burst_i;

    int n_pass  = 0;
    int n_total = 0;

    logic [LINE-1:0] exp_q[$];
    logic [LINE-1:0] obs_q[$];

    cacheline_burst_adapter #(.s_offset(5), .s_burst(64), .s_addr(32)) dut (
        .clk(clk), .rst(rst),
        .read_i(read_i), .write_i(write_i), .address_i(address_i), .line_i(line_i),
        .line_o(line_o), .resp_o(resp_o), .address_o(address_o),
        .read_o(read_o), .write_o(write_o), .burst_o(burst_o),
        .burst_i(burst_i), .resp_i(resp_i)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Fill driver: request, then acks per pat (bit p = cycle p after request, 1 beyond bit 15).
    task automatic drive_read(input logic [31:0] addr, input logic [LINE-1:0] data,
                              input logic [15:0] pat, input logic wr_too,
                              output logic got, output int cyc, output int rd_hi,
                              output int wr_hi, output logic first_rd,
                              output logic [LINE-1:0] first_line);
        int k;
        int p;
        k = 0;
        p = 0;
        read_i    = 1'b1;
        write_i   = wr_too;
        address_i = addr;
        line_i    = {8{$urandom}};
        exp_q.push_back(data);
        step();
        read_i     = 1'b0;
        write_i    = 1'b0;
        address_i  = $urandom;
        line_i     = '0;
        first_rd   = read_o;
        first_line = line_o;
        cyc = 1; rd_hi = 0; wr_hi = 0;
        while (!resp_o && cyc < 40) begin
            rd_hi += read_o ? 1 : 0;
            wr_hi += write_o ? 1 : 0;
            resp_i  = (p < 16) ? pat[p] : 1'b1;
            burst_i = (resp_i && k < 4) ? data[k*64 +: 64] : {$urandom, $urandom};
            step();
            if (resp_i) k++;
            p++;
            cyc++;
            resp_i  = 1'b0;
            burst_i = '0;
        end
        got = resp_o;
        if (resp_o) obs_q.push_back(line_o);
        $display("read  addr=%h latency=%0d read_o_cycles=%0d resp=%b", addr, cyc + 1, rd_hi, got);
    endtask

    // Writeback driver: per write_o cycle, expected beat from the ack-count model vs burst_o.
    task automatic drive_write(input logic [31:0] addr, input logic [LINE-1:0] data,
                               input logic [15:0] pat, output logic got, output int cyc,
                               output int wr_hi, output int rd_hi);
        int k;
        int p;
        k = 0;
        p = 0;
        write_i   = 1'b1;
        address_i = addr;
        line_i    = data;
        step();
        write_i   = 1'b0;
        address_i = $urandom;
        line_i    = {8{$urandom}};
        cyc = 1; wr_hi = 0; rd_hi = 0;
        while (!resp_o && cyc < 40) begin
            wr_hi += write_o ? 1 : 0;
            rd_hi += read_o ? 1 : 0;
            exp_q.push_back((k < 4) ? LINE'(data[k*64 +: 64]) : '0);
            obs_q.push_back(LINE'(burst_o));
            resp_i  = (p < 16) ? pat[p] : 1'b1;
            burst_i = {$urandom, $urandom};
            step();
            if (resp_i) k++;
            p++;
            cyc++;
            resp_i = 1'b0;
        end
        got = resp_o;
        $display("write addr=%h latency=%0d write_o_cycles=%0d resp=%b", addr, cyc + 1, wr_hi, got);
    endtask

    task automatic test_reset();
        logic got, frd;
        logic [LINE-1:0] fl, e, o;
        int cyc, rh, wh, seen;
        rst = 1'b1; read_i = 0; write_i = 0; resp_i = 0;
        address_i = '0; line_i = '0; burst_i = '0;
        step(); step();
        n_total++; if (read_o !== 1'b0) $display("FAIL rst_read_o got=%b want=0", read_o); else n_pass++;
        n_total++; if (write_o !== 1'b0) $display("FAIL rst_write_o got=%b want=0", write_o); else n_pass++;
        n_total++; if (resp_o !== 1'b0) $display("FAIL rst_resp_o got=%b want=0", resp_o); else n_pass++;
        n_total++; if (burst_o !== 64'd0) $display("FAIL rst_burst_o got=%h want=0", burst_o); else n_pass++;
        n_total++; if (address_o !== 32'd0) $display("FAIL rst_address_o got=%h want=0", address_o); else n_pass++;
        n_total++; if (line_o !== '0) $display("FAIL rst_line_o got=%h want=0", line_o); else n_pass++;
        rst = 1'b0;
        step();
        // Abort a fill after two acks.
        read_i = 1'b1; address_i = 32'hABCD_0040;
        step();
        read_i = 1'b0;
        resp_i = 1'b1; burst_i = {16{4'h5}};
        step();
        burst_i = {16{4'h6}};
        step();
        resp_i = 1'b0; burst_i = '0;
        rst = 1'b1;
        step();
        n_total++; if (line_o !== '0) $display("FAIL abort_line_o got=%h want=0", line_o); else n_pass++;
        n_total++; if (read_o !== 1'b0) $display("FAIL abort_read_o got=%b want=0", read_o); else n_pass++;
        n_total++; if (address_o !== 32'd0) $display("FAIL abort_address_o got=%h want=0", address_o); else n_pass++;
        step();
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            seen += (resp_o || read_o) ? 1 : 0;
            step();
        end
        n_total++; if (seen !== 0) $display("FAIL abort_quiet got=%0d want=0", seen); else n_pass++;
        exp_q.delete(); obs_q.delete();
        drive_read(32'h0000_2000, {64'h0D0D_0D0D_0D0D_0D0D, 64'h0C0C_0C0C_0C0C_0C0C,
                                   64'h0B0B_0B0B_0B0B_0B0B, 64'h0A0A_0A0A_0A0A_0A0A},
                   16'hFFFF, 1'b0, got, cyc, rh, wh, frd, fl);
        n_total++; if (got !== 1'b1) $display("FAIL post_rst_resp got=%b want=1", got); else n_pass++;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_total++;
            if (obs_q.size() == 0) $display("FAIL post_rst_line got=none want=%h", e);
            else begin
                o = obs_q.pop_front();
                if (o !== e) $display("FAIL post_rst_line got=%h want=%h", o, e); else n_pass++;
            end
        end
        step();
    endtask

    task automatic test_fill();
        logic got, frd;
        logic [LINE-1:0] fl, e, o;
        int cyc, rh, wh;
        exp_q.delete(); obs_q.delete();
        drive_read(32'h0000_1234, {{16{4'h4}}, {16{4'h3}}, {16{4'h2}}, {16{4'h1}}},
                   16'hFFFF, 1'b0, got, cyc, rh, wh, frd, fl);
        n_total++; if (got !== 1'b1) $display("FAIL fill_resp got=%b want=1", got); else n_pass++;
        n_total++; if (cyc + 1 !== 6) $display("FAIL fill_latency got=%0d want=6", cyc + 1); else n_pass++;
        n_total++; if (rh !== 4) $display("FAIL fill_read_o_cycles got=%0d want=4", rh); else n_pass++;
        n_total++; if (address_o !== 32'h0000_1220) $display("FAIL fill_address got=%h want=00001220", address_o); else n_pass++;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_total++;
            if (obs_q.size() == 0) $display("FAIL fill_line got=none want=%h", e);
            else begin
                o = obs_q.pop_front();
                if (o !== e) $display("FAIL fill_line got=%h want=%h", o, e); else n_pass++;
            end
        end
        step();
        n_total++; if (resp_o !== 1'b0) $display("FAIL fill_resp_pulse got=%b want=0", resp_o); else n_pass++;
    endtask

    task automatic test_stalled_writeback();
        logic got;
        logic [LINE-1:0] e, o;
        int cyc, wh, rh;
        exp_q.delete(); obs_q.delete();
        drive_write(32'h0000_8077, {{16{4'hD}}, {16{4'hC}}, {16{4'hB}}, {16{4'hA}}},
                    16'h0059, got, cyc, wh, rh);
        n_total++; if (got !== 1'b1) $display("FAIL wb_resp got=%b want=1", got); else n_pass++;
        n_total++; if (wh !== 7) $display("FAIL wb_write_o_cycles got=%0d want=7", wh); else n_pass++;
        n_total++; if (cyc + 1 !== 9) $display("FAIL wb_latency got=%0d want=9", cyc + 1); else n_pass++;
        n_total++; if (rh !== 0) $display("FAIL wb_read_o_cycles got=%0d want=0", rh); else n_pass++;
        n_total++; if (address_o !== 32'h0000_8060) $display("FAIL wb_address got=%h want=00008060", address_o); else n_pass++;
        n_total++; if (burst_o !== 64'd0) $display("FAIL wb_burst_idle got=%h want=0", burst_o); else n_pass++;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_total++;
            if (obs_q.size() == 0) $display("FAIL wb_beat got=none want=%h", e[63:0]);
            else begin
                o = obs_q.pop_front();
                if (o !== e) $display("FAIL wb_beat got=%h want=%h", o[63:0], e[63:0]); else n_pass++;
            end
        end
        step();
    endtask

    task automatic test_simultaneous();
        logic got, frd;
        logic [LINE-1:0] fl, e, o;
        int cyc, rh, wh;
        exp_q.delete(); obs_q.delete();
        drive_read(32'h0004_0100, {{8{8'h97}}, {8{8'h86}}, {8{8'h75}}, {8{8'h64}}},
                   16'hFFFD, 1'b1, got, cyc, rh, wh, frd, fl);
        n_total++; if (got !== 1'b1) $display("FAIL both_resp got=%b want=1", got); else n_pass++;
        n_total++; if (wh !== 0) $display("FAIL both_write_o_cycles got=%0d want=0", wh); else n_pass++;
        n_total++; if (rh !== 5) $display("FAIL both_read_o_cycles got=%0d want=5", rh); else n_pass++;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_total++;
            if (obs_q.size() == 0) $display("FAIL both_line got=none want=%h", e);
            else begin
                o = obs_q.pop_front();
                if (o !== e) $display("FAIL both_line got=%h want=%h", o, e); else n_pass++;
            end
        end
        step();
    endtask

    task automatic test_spurious();
        logic got, frd;
        logic [LINE-1:0] fl, e, o, prev, d1, d2;
        int cyc, rh, wh;
        exp_q.delete(); obs_q.delete();
        d1 = {64'h1357_9BDF_0246_8ACE, 64'hFEDC_BA98_7654_3210, 64'h0F0F_F0F0_0F0F_F0F0, 64'h1234_5678_9ABC_DEF0};
        d2 = {64'hCAFE_0000_0000_0003, 64'hCAFE_0000_0000_0002, 64'hCAFE_0000_0000_0001, 64'hCAFE_0000_0000_0000};
        prev = line_o;
        for (int i = 0; i < 3; i++) begin
            resp_i = 1'b1; burst_i = {$urandom, $urandom};
            step();
        end
        resp_i = 1'b0;
        n_total++; if (line_o !== prev) $display("FAIL idle_ack_line got=%h want=%h", line_o, prev); else n_pass++;
        n_total++; if (read_o !== 1'b0) $display("FAIL idle_ack_read_o got=%b want=0", read_o); else n_pass++;
        drive_read(32'h0000_0400, d1, 16'hFFFF, 1'b0, got, cyc, rh, wh, frd, fl);
        resp_i = 1'b1; burst_i = {$urandom, $urandom};
        step();
        resp_i = 1'b0; burst_i = '0;
        n_total++; if (line_o !== d1) $display("FAIL done_ack_line got=%h want=%h", line_o, d1); else n_pass++;
        n_total++; if (resp_o !== 1'b0) $display("FAIL done_ack_resp got=%b want=0", resp_o); else n_pass++;
        drive_read(32'h0000_0420, d2, 16'hFFFF, 1'b0, got, cyc, rh, wh, frd, fl);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_total++;
            if (obs_q.size() == 0) $display("FAIL spur_line got=none want=%h", e);
            else begin
                o = obs_q.pop_front();
                if (o !== e) $display("FAIL spur_line got=%h want=%h", o, e); else n_pass++;
            end
        end
        step();
    endtask

    task automatic test_back_to_back();
        logic got, frd;
        logic [LINE-1:0] fl, e, o, da, db;
        int cyc, rh, wh;
        exp_q.delete(); obs_q.delete();
        da = {64'hAAAA_0000_0000_0004, 64'hAAAA_0000_0000_0003, 64'hAAAA_0000_0000_0002, 64'hAAAA_0000_0000_0001};
        db = {64'hBBBB_0000_0000_0004, 64'hBBBB_0000_0000_0003, 64'hBBBB_0000_0000_0002, 64'hBBBB_0000_0000_0001};
        drive_read(32'h0001_0000, da, 16'hFFFF, 1'b0, got, cyc, rh, wh, frd, fl);
        step();
        drive_read(32'h0001_0020, db, 16'hFFFE, 1'b0, got, cyc, rh, wh, frd, fl);
        n_total++; if (frd !== 1'b1) $display("FAIL b2b_read_o got=%b want=1", frd); else n_pass++;
        n_total++; if (fl !== da) $display("FAIL b2b_line_retained got=%h want=%h", fl, da); else n_pass++;
        n_total++; if (got !== 1'b1) $display("FAIL b2b_resp got=%b want=1", got); else n_pass++;
        n_total++; if (cyc + 1 !== 7) $display("FAIL b2b_latency got=%0d want=7", cyc + 1); else n_pass++;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_total++;
            if (obs_q.size() == 0) $display("FAIL b2b_line got=none want=%h", e);
            else begin
                o = obs_q.pop_front();
                if (o !== e) $display("FAIL b2b_line got=%h want=%h", o, e); else n_pass++;
            end
        end
        step();
    endtask

    initial begin
        test_reset();
        test_fill();
        test_stalled_writeback();
        test_simultaneous();
        test_spurious();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
